// File: rtl/braille_pkg.sv
// Shared Braille definitions: widths, FSM states and the code-to-dots pattern table.
package braille_pkg;

  localparam int CODE_W = 4;
  localparam int DOT_W  = 6;
  localparam logic [CODE_W-1:0] CODE_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  // bit0 = dot 1, matching the switch input of the decoder this block inverts
  function automatic logic [DOT_W-1:0] code2dots(input logic [CODE_W-1:0] code);
    logic [DOT_W-1:0] pattern;
    case (code)
      4'h0:    pattern = 6'b000001;
      4'h1:    pattern = 6'b000101;
      4'h2:    pattern = 6'b000011;
      4'h3:    pattern = 6'b001011;
      4'h4:    pattern = 6'b001001;
      4'h5:    pattern = 6'b000111;
      4'h6:    pattern = 6'b001111;
      4'h7:    pattern = 6'b001101;
      4'h8:    pattern = 6'b000110;
      4'h9:    pattern = 6'b001110;
      4'hA:    pattern = 6'b010101;
      4'hB:    pattern = 6'b011001;
      4'hC:    pattern = 6'b010111;
      4'hD:    pattern = 6'b010110;
      4'hE:    pattern = 6'b110001;
      default: pattern = 6'b000000;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/braille_encode_lut.sv
// Combinational alphabet code -> Braille cell lookup with an invalid-code flag;
// also used by the switch checker to compare user input against the prompted cell.
module braille_encode_lut
  import braille_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [DOT_W-1:0]  dots,
  output logic              invalid
);

  assign dots    = code2dots(code);
  assign invalid = (code == CODE_INVALID);

endmodule

// File: rtl/alphabet2braille_display.sv
// Displays one Braille cell per accepted code for HOLD_CYCLES, then blanks for GAP_CYCLES.
// Optional macro BRAILLE_TX_COUNT_EN adds an 8-bit letter_count of displayed valid codes.
module alphabet2braille_display
  import braille_pkg::*;
#(
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              letter_valid,
  input  logic [CODE_W-1:0] letter_in,
  output logic              letter_ready,
  output logic [DOT_W-1:0]  dots,
  output logic              showing,
  output logic              err
`ifdef BRAILLE_TX_COUNT_EN
  ,
  output logic [7:0]        letter_count
`endif
);

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_C  = (MAX_HG > 2) ? MAX_HG : 2;
  localparam int CNT_W  = $clog2(MAX_C);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DOT_W-1:0]   dots_q, dots_d;
  logic               showing_q, showing_d;
  logic               err_q, err_d;
  logic [DOT_W-1:0]   lut_dots;
  logic               lut_invalid;
  logic               accept;
`ifdef BRAILLE_TX_COUNT_EN
  logic [7:0]         count_q, count_d;
`endif

  braille_encode_lut u_lut (
    .code    (letter_in),
    .dots    (lut_dots),
    .invalid (lut_invalid)
  );

  assign letter_ready = (state_q == IDLE);
  assign accept       = letter_valid & letter_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dots_d    = dots_q;
    showing_d = showing_q;
    err_d     = 1'b0;
`ifdef BRAILLE_TX_COUNT_EN
    count_d   = count_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (lut_invalid) begin
            err_d = 1'b1;
          end else begin
            state_d   = SHOW;
            cnt_d     = HOLD_LOAD;
            dots_d    = lut_dots;
            showing_d = 1'b1;
`ifdef BRAILLE_TX_COUNT_EN
            count_d   = count_q + 8'd1;
`endif
          end
        end
      end
      SHOW: begin
        if (cnt_q == '0) begin
          // blanking starts on the same edge that ends the hold
          dots_d    = '0;
          showing_d = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        dots_d    = '0;
        showing_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dots_q    <= '0;
      showing_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef BRAILLE_TX_COUNT_EN
      count_q   <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dots_q    <= dots_d;
      showing_q <= showing_d;
      err_q     <= err_d;
`ifdef BRAILLE_TX_COUNT_EN
      count_q   <= count_d;
`endif
    end
  end

  assign dots    = dots_q;
  assign showing = showing_q;
  assign err     = err_q;
`ifdef BRAILLE_TX_COUNT_EN
  assign letter_count = count_q;
`endif

endmodule

// File: tb/tb_alphabet2braille_display.sv
// Self-checking bench: pattern table sweep with a dots scoreboard plus hand-written corner cases.
module tb_alphabet2braille_display;

  localparam int HOLD = 4;
  localparam int GAPC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       letter_valid = 1'b0;
  logic [3:0] letter_in = 4'd0;
  logic       letter_ready;
  logic [5:0] dots;
  logic       showing;
  logic       err;
  logic       v0 = 1'b0;
  logic [3:0] c0 = 4'd0;
  logic       ready0;
  logic [5:0] dots0;
  logic       showing0;
  logic       err0;
`ifdef BRAILLE_TX_COUNT_EN
  logic [7:0] letter_count;
  logic [7:0] letter_count0;
`endif

  always #5 clk = ~clk;

  alphabet2braille_display #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .letter_valid (letter_valid),
    .letter_in    (letter_in),
    .letter_ready (letter_ready),
    .dots         (dots),
    .showing      (showing),
    .err          (err)
`ifdef BRAILLE_TX_COUNT_EN
    ,
    .letter_count (letter_count)
`endif
  );

  alphabet2braille_display #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(0)) dut0 (
    .clk          (clk),
    .rst          (rst),
    .letter_valid (v0),
    .letter_in    (c0),
    .letter_ready (ready0),
    .dots         (dots0),
    .showing      (showing0),
    .err          (err0)
`ifdef BRAILLE_TX_COUNT_EN
    ,
    .letter_count (letter_count0)
`endif
  );

  typedef struct {
    logic [3:0] code;
    logic [5:0] dots;
  } vec_t;

  vec_t       tbl[15];
  logic [5:0] exp_q[$];
  int         checks = 0;
  int         fails = 0;
  int         cyc = 0;
  int         run_len = 0;
  logic       prev_showing = 1'b0;
  int         exp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // one clock; outputs sampled 1 time unit after the edge, scoreboard updated here
  task automatic tick();
    logic [5:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (showing && !prev_showing) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_show", {26'd0, dots}, 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_dots", {26'd0, dots}, {26'd0, e});
        $display("show dots=%b expected=%b cycle=%0d", dots, e, cyc);
      end
      run_len = 0;
    end
    if (showing) run_len++;
    if (!showing && prev_showing) check("sb_hold_len", run_len, HOLD);
    prev_showing = showing;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!letter_ready && n < 50) begin
      tick();
      n++;
    end
    if (!letter_ready) check("ready_timeout", 0, 1);
  endtask

  initial begin
    int last_acc;
    tbl[0]  = '{4'h0, 6'b000001}; tbl[1]  = '{4'h1, 6'b000101};
    tbl[2]  = '{4'h2, 6'b000011}; tbl[3]  = '{4'h3, 6'b001011};
    tbl[4]  = '{4'h4, 6'b001001}; tbl[5]  = '{4'h5, 6'b000111};
    tbl[6]  = '{4'h6, 6'b001111}; tbl[7]  = '{4'h7, 6'b001101};
    tbl[8]  = '{4'h8, 6'b000110}; tbl[9]  = '{4'h9, 6'b001110};
    tbl[10] = '{4'hA, 6'b010101}; tbl[11] = '{4'hB, 6'b011001};
    tbl[12] = '{4'hC, 6'b010111}; tbl[13] = '{4'hD, 6'b010110};
    tbl[14] = '{4'hE, 6'b110001};

    // 1: async reset takes effect before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_dots", {26'd0, dots}, 0);
    check("rst_showing", {31'd0, showing}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_ready", {31'd0, letter_ready}, 1);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 2: single code 0, full hold/gap timing
    letter_in = 4'h0; letter_valid = 1'b1;
    exp_q.push_back(6'b000001);
    tick();
    letter_valid = 1'b0;
    exp_count++;
    for (int i = 0; i < HOLD; i++) begin
      check("t2_hold_dots", {26'd0, dots}, 32'h01);
      check("t2_hold_ready", {31'd0, letter_ready}, 0);
      tick();
    end
    for (int i = 0; i < GAPC; i++) begin
      check("t2_gap_dots", {26'd0, dots}, 0);
      check("t2_gap_showing", {31'd0, showing}, 0);
      check("t2_gap_ready", {31'd0, letter_ready}, 0);
      tick();
    end
    check("t2_ready_after", {31'd0, letter_ready}, 1);

    // 3: back-to-back sweep, valid held
    letter_valid = 1'b1;
    last_acc = 0;
    for (int i = 0; i < 15; i++) begin
      letter_in = tbl[i].code;
      exp_q.push_back(tbl[i].dots);
      wait_ready();
      tick();
      exp_count++;
      if (i > 0) check("t3_period", cyc - last_acc, 1 + HOLD + GAPC);
      last_acc = cyc;
    end
    letter_valid = 1'b0;
    wait_ready();
`ifdef BRAILLE_TX_COUNT_EN
    check("t3_count", {24'd0, letter_count}, exp_count);
`endif

    // 4: invalid code
    letter_in = 4'hF; letter_valid = 1'b1;
    tick();
    letter_valid = 1'b0;
    check("t4_err_pulse", {31'd0, err}, 1);
    check("t4_dots", {26'd0, dots}, 0);
    check("t4_ready", {31'd0, letter_ready}, 1);
    tick();
    check("t4_err_clear", {31'd0, err}, 0);
    check("t4_showing", {31'd0, showing}, 0);
`ifdef BRAILLE_TX_COUNT_EN
    check("t4_count", {24'd0, letter_count}, exp_count);
`endif

    // 5: letter_in changes during SHOW are ignored
    letter_in = 4'hE; letter_valid = 1'b1;
    exp_q.push_back(6'b110001);
    tick();
    exp_count++;
    for (int i = 0; i < HOLD; i++) begin
      letter_in = 4'($urandom_range(0, 15));
      check("t5_dots_hold", {26'd0, dots}, 32'h31);
      tick();
    end
    letter_valid = 1'b0;
    wait_ready();

    // 6: reset during the second SHOW cycle
    letter_in = 4'h9; letter_valid = 1'b1;
    exp_q.push_back(6'b001110);
    tick();
    letter_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("t6_rst_dots", {26'd0, dots}, 0);
    check("t6_rst_showing", {31'd0, showing}, 0);
    check("t6_rst_ready", {31'd0, letter_ready}, 1);
    prev_showing = 1'b0;
    run_len = 0;
    exp_count = 0;
    tick();
    rst = 1'b0;
    tick();
    check("t6_idle_after", {31'd0, letter_ready}, 1);
    letter_in = 4'h7; letter_valid = 1'b1;
    exp_q.push_back(6'b001101);
    tick();
    letter_valid = 1'b0;
    exp_count++;
    check("t6_next_dots", {26'd0, dots}, 32'h0D);
    wait_ready();
`ifdef BRAILLE_TX_COUNT_EN
    check("t6_count", {24'd0, letter_count}, exp_count);
`endif

    // 7: zero-gap instance
    c0 = 4'h3; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      check("t7_dots", {26'd0, dots0}, 32'h0B);
      check("t7_showing", {31'd0, showing0}, 1);
      check("t7_ready_low", {31'd0, ready0}, 0);
      tick();
    end
    check("t7_ready_high", {31'd0, ready0}, 1);
    check("t7_dots_clear", {26'd0, dots0}, 0);

    check("sb_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
